// File: rtl/serial_frame_tx_pkg.sv
// Shared frame-transmitter definitions: FSM state encodings and the idle line level.
// The matching receiver imports the same header.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise.
// tick marks the last cycle of each bit period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even
// parity, STOP_BITS stop bits. The line output is registered.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              q,
    output logic              busy
);

    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_W - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    tx_state_t         state, state_nx;
    logic [DATA_W-1:0] sh, sh_nx, sh_shifted;
    logic [IW-1:0]     idx, idx_nx;
    logic              par, par_nx;
    logic              q_nx;
    logic              tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (state != IDLE),
        .tick(tick)
    );

    assign ready      = (state == IDLE);
    assign busy       = !ready;
    assign sh_shifted = sh >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sh    <= '0;
            idx   <= '0;
            par   <= 1'b0;
            q     <= LINE_IDLE;
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            idx   <= idx_nx;
            par   <= par_nx;
            q     <= q_nx;
        end
    end

    // q_nx is the line level of the state being entered, so q changes on the
    // same edge as the state/bit transition.
    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        idx_nx   = idx;
        par_nx   = par;
        q_nx     = q;
        case (state)
            IDLE: begin
                q_nx = LINE_IDLE;
                if (valid) begin
                    sh_nx    = data;
                    par_nx   = ^data;
                    idx_nx   = '0;
                    state_nx = START;
                    q_nx     = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_nx = DATA;
                    idx_nx   = '0;
                    q_nx     = sh[0];
                end
            end
            DATA: begin
                if (tick) begin
                    sh_nx = sh_shifted;
                    if (idx == LAST_DATA) begin
                        idx_nx = '0;
                        if (PARITY_EN != 0) begin
                            state_nx = PARITY;
                            q_nx     = par;
                        end else begin
                            state_nx = STOP;
                            q_nx     = LINE_IDLE;
                        end
                    end else begin
                        idx_nx = idx + 1'b1;
                        q_nx   = sh_shifted[0];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nx = STOP;
                    idx_nx   = '0;
                    q_nx     = LINE_IDLE;
                end
            end
            STOP: begin
                q_nx = LINE_IDLE;
                if (tick) begin
                    if (idx == LAST_STOP) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                q_nx     = LINE_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: three configurations (defaults, parity with two
// stop bits, one-bit/one-clock) checked against hand-computed line waveforms.
module tb_serial_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic [0:0] data2 = '0;
    logic       valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0;
    logic       ready0, ready1, ready2;
    logic       q0, q1, q2;
    logic       busy0, busy1, busy2;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst0), .data(data0), .valid(valid0),
        .ready(ready0), .q(q0), .busy(busy0));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst1), .data(data1), .valid(valid1),
        .ready(ready1), .q(q1), .busy(busy1));

    serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(1), .PARITY_EN(0), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst2), .data(data2), .valid(valid2),
        .ready(ready2), .q(q2), .busy(busy2));

    int checks   = 0;
    int failures = 0;
    int sel      = 0;
    logic q_m, ready_m, busy_m;

    always_comb begin
        q_m = q0; ready_m = ready0; busy_m = busy0;
        if (sel == 1) begin q_m = q1; ready_m = ready1; busy_m = busy1; end
        if (sel == 2) begin q_m = q2; ready_m = ready2; busy_m = busy2; end
    end

    typedef struct {
        logic [7:0]  d;
        logic [15:0] frame;   // line levels, first-transmitted bit in the highest used position
        int          nbits;
    } vec_t;

    vec_t vecs0 [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after the accept edge; ends #1 after the first idle edge.
    task automatic check_frame(input string name, input logic [15:0] frame,
                               input int nbits, input int cpb);
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < cpb; k++) begin
                chk({name, "_q"}, 32'(q_m), 32'(frame[nbits-1-b]));
                chk({name, "_busy"}, 32'(busy_m), 32'd1);
                @(posedge clk); #1;
            end
        end
        chk({name, "_ready_end"}, 32'(ready_m), 32'd1);
        chk({name, "_busy_end"}, 32'(busy_m), 32'd0);
        chk({name, "_q_end"}, 32'(q_m), 32'd1);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready_m && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready_wait"}, 32'(ready_m), 32'd1);
    endtask

    task automatic send(input int s, input logic [7:0] d, input logic [15:0] frame,
                        input int nbits, input int cpb, input string name);
        sel = s;
        @(negedge clk);
        wait_ready(name);
        case (s)
            0: begin data0 = d; valid0 = 1'b1; end
            1: begin data1 = d; valid1 = 1'b1; end
            default: begin data2 = d[0:0]; valid2 = 1'b1; end
        endcase
        @(posedge clk); #1;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        data0 = ~d; data1 = ~d; data2 = ~d[0:0];
        check_frame(name, frame, nbits, cpb);
    endtask

    initial begin
        vecs0[0] = '{8'h00, 16'b0_00000000_1, 10};
        vecs0[1] = '{8'hFF, 16'b0_11111111_1, 10};
        vecs0[2] = '{8'h3C, 16'b0_00111100_1, 10};
        vecs0[3] = '{8'h01, 16'b0_10000000_1, 10};
        vecs0[4] = '{8'hA5, 16'b0_10100101_1, 10};

        // Reset held with valid asserted: everything idle.
        valid0 = 1'b1; data0 = 8'hA5; valid1 = 1'b1; valid2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_q0", 32'(q0), 32'd1);
            chk("rst_ready0", 32'(ready0), 32'd1);
            chk("rst_busy0", 32'(busy0), 32'd0);
            chk("rst_q1", 32'(q1), 32'd1);
            chk("rst_q2", 32'(q2), 32'd1);
        end
        valid1 = 1'b0; valid2 = 1'b0;
        @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        sel = 0;
        @(posedge clk); #1;
        valid0 = 1'b0; data0 = 8'h00;
        check_frame("first_a5", 16'b0_10100101_1, 10, 4);

        for (int i = 0; i < 5; i++)
            send(0, vecs0[i].d, vecs0[i].frame, vecs0[i].nbits, 4, $sformatf("vec%0d", i));

        // Back-to-back with valid held: exactly one idle cycle between frames.
        sel = 0;
        @(negedge clk);
        data0 = 8'h3C; valid0 = 1'b1;
        @(posedge clk); #1;
        data0 = 8'hC3;
        check_frame("b2b_3c", 16'b0_00111100_1, 10, 4);
        @(posedge clk); #1;
        valid0 = 1'b0; data0 = 8'h00;
        check_frame("b2b_c3", 16'b0_11000011_1, 10, 4);

        // Reset during data bit 3 of 0xFF.
        @(negedge clk);
        data0 = 8'hFF; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_busy_before", 32'(busy0), 32'd1);
        rst0 = 1'b0;
        #1;
        chk("mid_q", 32'(q0), 32'd1);
        chk("mid_ready", 32'(ready0), 32'd1);
        chk("mid_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle_q", 32'(q0), 32'd1);
        chk("post_rst_idle_ready", 32'(ready0), 32'd1);
        send(0, 8'h01, 16'b0_10000000_1, 10, 4, "post_rst_01");

        // Parity + two stop bits.
        send(1, 8'h07, 16'b0_11100000_1_11, 12, 4, "par_07");
        send(1, 8'hA5, 16'b0_10100101_0_11, 12, 4, "par_a5");

        // One data bit, one clock per bit.
        send(2, 8'h01, 16'b011, 3, 1, "cpb1_1");
        send(2, 8'h00, 16'b001, 3, 1, "cpb1_0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
